// File: rtl/uart_pkg.sv
// Purpose: shared UART types and constants for the transmit/receive paths.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity state is enabled by UART_TX_PARITY_EN.
package uart_pkg;

  localparam int   DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int   UART_DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/fifo_8x64.sv
// Purpose: generic 8-bit x 64-entry synchronous FIFO (TX byte buffer).
// Latency: data_out valid the cycle after an accepted rd_en; empty clears the cycle after a write.
// Backpressure: writes ignored while full, reads ignored while empty.
module fifo_8x64 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [64];
  logic [6:0] wptr;
  logic [6:0] rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[6] != rptr[6]) && (wptr[5:0] == rptr[5:0]);

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[5:0]] <= data_in;
  end

  // Pointers and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 7'd1;
      if (rd_en && !empty) begin
        data_out <= mem[rptr[5:0]];
        rptr     <= rptr + 7'd1;
      end
    end
  end

endmodule

// File: rtl/uart_baud_tick.sv
// Purpose: bit-period counter; tick marks the last cycle of each CLKS_PER_BIT period.
// Latency: first tick CLKS_PER_BIT cycles after clr is released (counter restarts at 0).
// Backpressure: none; clr holds the counter at zero and suppresses tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;

  // Free-running 0..CLKS_PER_BIT-1 counter, parked at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr)             baud_cnt <= '0;
    else if (baud_cnt == LAST)  baud_cnt <= '0;
    else                        baud_cnt <= baud_cnt + CW'(1);
  end

  assign tick = !clr && (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Purpose: UART 8N1/8N2 transmitter that pops bytes from the TX FIFO and serialises them on tx.
// Latency: tx falls 3 clocks after fifo_empty deasserts; frame = (9+STOP_BITS[+1 parity]) bit periods.
// Backpressure: pops only when enable && !fifo_empty in IDLE; one byte in flight. Parity via UART_TX_PARITY_EN.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP     = 1'(STOP_BITS - 1);

  uart_tx_state_t state, state_nxt;
  logic [7:0]     shift, shift_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [2:0]     bit_idx_inc;
  logic           stop_cnt, stop_cnt_nxt;
  logic           tx_nxt, rd_nxt, busy_nxt, done_nxt;
  logic           baud_clr, baud_tick;

  assign bit_idx_inc = bit_idx + 3'd1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // State and all outputs are registered so tx/busy/tx_done are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_idx    <= bit_idx_nxt;
      stop_cnt   <= stop_cnt_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_nxt;
      busy       <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

  // Next-state and next-output decode; the baud counter runs only while a bit is on the line.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    rd_nxt       = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    baud_clr     = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_clr = 1'b1;
        tx_nxt   = UART_IDLE_LEVEL;
        if (enable && !fifo_empty) begin
          rd_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ST_READ;
        end
      end

      // FIFO pops on the edge leaving this state.
      ST_READ: begin
        baud_clr  = 1'b1;
        state_nxt = ST_LATCH;
      end

      // Popped byte is on fifo_data now; start bit begins on this edge.
      ST_LATCH: begin
        baud_clr  = 1'b1;
        shift_nxt = fifo_data;
        tx_nxt    = 1'b0;
        state_nxt = ST_START;
      end

      ST_START: begin
        if (baud_tick) begin
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt       = ^shift;
            state_nxt    = ST_PARITY;
`else
            tx_nxt       = UART_IDLE_LEVEL;
            stop_cnt_nxt = 1'b0;
            state_nxt    = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = shift[bit_idx_inc];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          tx_nxt       = UART_IDLE_LEVEL;
          stop_cnt_nxt = 1'b0;
          state_nxt    = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        tx_nxt    = UART_IDLE_LEVEL;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
